// File: rtl/bpu_btb.sv
// bpu_btb -- branch target buffer with 2-bit saturating direction counters.
//
// Looked up combinationally with the IF-stage PC. Trained by the EX stage
// when a control transfer resolves. The mispredict/recover_pc pair tells the
// pipeline interlock whether fetch must be redirected, and where to.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en                  global enable; low freezes all state
//   if_pc               fetch word address (lookup)
//   pred_taken          lookup hit with counter in a taken state
//   pred_pc_new         predicted target, 0 when pred_taken is low
//   upd_*               EX-stage resolution info used for checking and training
//   flush_all           invalidate every entry
//   mispredict          redirect required for the EX-stage instruction
//   recover_pc          correct fetch address when mispredict is high
//   stat_ctl/stat_miss  saturating counts of control transfers / mispredicts
//
// Build option: define BPU_STATS_EN to implement the statistics counters;
// without it both stat outputs are tied to zero.

module bpu_btb #(
    parameter int AddrBits = 10,
    parameter int Entries  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [AddrBits-1:0] if_pc,
    output logic                pred_taken,
    output logic [AddrBits-1:0] pred_pc_new,
    input  logic                upd_valid,
    input  logic [AddrBits-1:0] upd_pc,
    input  logic [AddrBits-1:0] upd_pc_4,
    input  logic                upd_is_jump,
    input  logic                upd_is_branch,
    input  logic                upd_taken,
    input  logic [AddrBits-1:0] upd_target,
    input  logic                upd_pred_taken,
    input  logic [AddrBits-1:0] upd_pred_pc,
    input  logic                flush_all,
    output logic                mispredict,
    output logic [AddrBits-1:0] recover_pc,
    output logic [31:0]         stat_ctl,
    output logic [31:0]         stat_miss
);

    localparam int IdxBits = $clog2(Entries);
    localparam int TagBits = AddrBits - IdxBits;

    logic                valid_q  [Entries];
    logic [TagBits-1:0]  tag_q    [Entries];
    logic [AddrBits-1:0] target_q [Entries];
    logic [1:0]          ctr_q    [Entries];

    // ---------------- lookup ----------------
    logic [IdxBits-1:0] lk_idx;
    logic [TagBits-1:0] lk_tag;
    logic               lk_hit;

    assign lk_idx      = if_pc[IdxBits-1:0];
    assign lk_tag      = if_pc[AddrBits-1:IdxBits];
    assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken  = lk_hit && ctr_q[lk_idx][1];
    assign pred_pc_new = pred_taken ? target_q[lk_idx] : '0;

    // ---------------- resolution check ----------------
    logic ctl;
    logic act;

    assign ctl = upd_valid && (upd_is_jump || upd_is_branch);
    assign act = upd_is_jump || upd_taken;

    // A prediction on a non-control instruction (false hit) also counts,
    // because (ctl && act) is 0 there while upd_pred_taken is 1.
    assign mispredict = upd_valid &&
                        ((upd_pred_taken != (ctl && act)) ||
                         (upd_pred_taken && act && (upd_pred_pc != upd_target)));
    assign recover_pc = (ctl && act) ? upd_target : upd_pc_4;

    // ---------------- training ----------------
    logic [IdxBits-1:0]  up_idx;
    logic [TagBits-1:0]  up_tag;
    logic                up_hit;
    logic                wr_en;
    logic                wr_valid;
    logic [TagBits-1:0]  wr_tag;
    logic [AddrBits-1:0] wr_target;
    logic [1:0]          wr_ctr;

    assign up_idx = upd_pc[IdxBits-1:0];
    assign up_tag = upd_pc[AddrBits-1:IdxBits];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        wr_en     = 1'b0;
        wr_valid  = valid_q[up_idx];
        wr_tag    = tag_q[up_idx];
        wr_target = target_q[up_idx];
        wr_ctr    = ctr_q[up_idx];
        if (upd_valid) begin
            if (ctl) begin
                if (up_hit) begin
                    wr_en = 1'b1;
                    if (upd_is_jump) begin
                        wr_ctr = 2'b11;
                    end else if (upd_taken) begin
                        wr_ctr = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'd1;
                    end else begin
                        wr_ctr = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'd1;
                    end
                    if (act) begin
                        wr_target = upd_target;
                    end
                end else if (act) begin
                    // Miss on a taken transfer: allocate over whatever is there.
                    wr_en     = 1'b1;
                    wr_valid  = 1'b1;
                    wr_tag    = up_tag;
                    wr_target = upd_target;
                    wr_ctr    = upd_is_jump ? 2'b11 : 2'b10;
                end
            end else if (up_hit) begin
                // Non-control instruction aliased onto an entry: drop it.
                wr_en    = 1'b1;
                wr_valid = 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < Entries; gi++) begin : g_entry
            localparam logic [IdxBits-1:0] EntryIdx = IdxBits'(gi);
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q[gi]  <= 1'b0;
                    tag_q[gi]    <= '0;
                    target_q[gi] <= '0;
                    ctr_q[gi]    <= 2'b00;
                end else if (en) begin
                    if (flush_all) begin
                        // Flush suppresses any same-cycle training write.
                        valid_q[gi] <= 1'b0;
                    end else if (wr_en && (up_idx == EntryIdx)) begin
                        valid_q[gi]  <= wr_valid;
                        tag_q[gi]    <= wr_tag;
                        target_q[gi] <= wr_target;
                        ctr_q[gi]    <= wr_ctr;
                    end
                end
            end
        end
    endgenerate

    // ---------------- statistics ----------------
`ifdef BPU_STATS_EN
    logic [31:0] stat_ctl_q;
    logic [31:0] stat_miss_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ctl_q  <= '0;
            stat_miss_q <= '0;
        end else if (en) begin
            if (ctl && (stat_ctl_q != 32'hFFFF_FFFF)) begin
                stat_ctl_q <= stat_ctl_q + 32'd1;
            end
            if (mispredict && (stat_miss_q != 32'hFFFF_FFFF)) begin
                stat_miss_q <= stat_miss_q + 32'd1;
            end
        end
    end

    assign stat_ctl  = stat_ctl_q;
    assign stat_miss = stat_miss_q;
`else
    assign stat_ctl  = 32'd0;
    assign stat_miss = 32'd0;
`endif

endmodule
